ffe_slicer: RTL and testbench
=============================

Name: ffe_slicer

Overview:
- Transposed-form 7-tap feed-forward equalizer (FFE) with a PAM2 slicer.
- Consumes the packed coefficient bus produced by the LMS coefficient-update stage. Produces the equalized sample, the symbol decision, and the error word fed back to that stage's i_error.
- Sits between the channel front-end (sample source) and the symbol sink.
- Error output is held at zero during pipeline fill, so adaptation never sees uninitialised taps.

Parameters:
- DATA_BW, 9, input sample width, S(9,7).
- COEF_BW, 9, coefficient width, S(9,7).
- N_COEF, 7, number of taps.
- ERR_BW, 8, error width, S(8,6).
- N_WARMUP, 8, number of accepted samples after reset before o_err_valid asserts; must be >= N_COEF+1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  sample strobe; one input sample accepted per cycle with i_en=1
- i_data  in  DATA_BW  input sample S(9,7)
- i_coefs  in  COEF_BW*N_COEF  packed coefficients; tap k at bits [COEF_BW*(k+1)-1 : COEF_BW*k], tap 0 = LSBs
- o_y  out  DATA_BW  equalized sample S(9,7), saturated
- o_dec  out  DATA_BW  slicer decision S(9,7): +128 (+1.0) or -128 (-1.0)
- o_err  out  ERR_BW  error d-y, S(8,6), saturated
- o_valid  out  1  o_y/o_dec valid strobe
- o_err_valid  out  1  o_err meaningful (warm-up complete)

Behaviour:
- Reset (i_rst=1 at clock edge):
  - All partial-sum registers, o_y, o_dec, o_err, o_valid and o_err_valid clear to 0.
  - Warm-up counter clears to 0.
  - Reset mid-stream discards all in-flight partial sums.
- Products:
  - p_k = i_data * c_k, S(18,14), full precision.
  - Sign-extend to S(21,14) accumulators; the sum of 7 products cannot overflow.
- Transposed chain, updated only when i_en=1:
  - s[N_COEF-1] <= p[N_COEF-1]
  - s[k] <= p[k] + s[k+1] for k = N_COEF-2 .. 1
  - acc = p[0] + s[1], combinational.
- Stage 1 register (on i_en):
  - y_full = acc.
  - o_y = acc rounded to S(9,7): add 2^6, arithmetic shift right 7, saturate to [-256, 255].
  - o_valid <= i_en.
  - Latency i_data -> o_y is 1 clock.
  - When i_en=0: o_valid=0 and all registers hold.
- Stage 2 slicer (registered; o_dec and o_err are 1 clock after o_y):
  - o_dec = +128 if o_y >= 0, else -128. Zero maps to +1.
  - e = o_dec - o_y, computed in S(10,7).
  - o_err = e arithmetic shift right 1 (truncate), saturated to [-128, 127].
  - Sign convention: positive error means output below decision, matching the LMS update c += mu*e*x.
- o_dec/o_err strobe: asserted one cycle after o_valid.
  - The bench checks o_dec/o_err on the cycle after o_valid.
  - The design exposes no separate dec-valid port; o_err_valid gates error use.
- Warm-up counter:
  - Saturating; increments on each i_en until it reaches N_WARMUP, then holds.
  - o_err_valid = (count == N_WARMUP), registered and aligned with o_err.
  - While o_err_valid=0, o_err is forced to 0, so the downstream LMS sees zero correction.
- Coefficient changes on i_coefs take effect on the next i_en edge; there is no internal coefficient latch.
  - Taps with partial sums in flight use the coefficients present when each product was registered; transposed-form semantics are accepted.
- Simultaneous i_rst and i_en: reset wins.

Decomposition:
- Shared package holds:
  - Fixed-point widths: DATA_BW, COEF_BW, ERR_BW, ACC_BW=21.
  - Fractional-bit constants: FRAC_DATA=7, FRAC_ERR=6.
  - PAM2 level constants: LVL_P1=+128, LVL_M1=-128.
  - A saturate function, reused by the LMS stage.
- One sub-module, ffe_sat_round (round-half-up plus saturate, parameterised input/output width and shift).
  - Instantiated for o_y and for o_err (shift 1, truncate mode).

Test Plan:
- Identity: c3=128, others 0; i_data impulse 100 then zeros, i_en held high.
  - o_y=100 appears exactly 3 strobes after the input plus 1 clock latency; all other outputs 0.
  - o_dec=+128; o_err=(128-100)>>1=14 once warm-up is done.
- Warm-up: random data, i_en=1 continuously.
  - o_err=0 and o_err_valid=0 for the first N_WARMUP samples.
  - From sample N_WARMUP+1, o_err_valid=1 and o_err is nonzero where expected.
- Saturation: all taps +255, i_data=+255 for 7 samples.
  - o_y=255; o_dec=+128; o_err=(128-255)>>1=-64.
  - Negative case: all taps and data at -256 gives o_y=255 (positive product), not wraparound.
- Gated enable: i_en toggled 1,0,0,1 with identity taps.
  - Registers hold while i_en=0; the output sequence equals the enabled-only sequence; o_valid pulses only after enabled cycles.
- Reset mid-stream: assert i_rst for 1 cycle after 10 samples.
  - Next cycle all outputs are 0 and o_err_valid=0; the warm-up counter restarts and prior partial sums never reach o_y.
- Zero boundary: output exactly 0 gives o_dec=+128 and o_err=64.

Source files
------------

// File: rtl/ffe_slicer_pkg.sv
// Shared fixed-point definitions for the FFE / slicer / LMS datapath.
package ffe_slicer_pkg;

    // Fixed-point widths
    localparam int DATA_BW   = 9;   // S(9,7) samples
    localparam int COEF_BW   = 9;   // S(9,7) coefficients
    localparam int ERR_BW    = 8;   // S(8,6) error
    localparam int N_COEF    = 7;
    localparam int ACC_BW    = 21;  // S(21,14) tap accumulators

    // Fractional bits
    localparam int FRAC_DATA = 7;
    localparam int FRAC_COEF = 7;
    localparam int FRAC_ERR  = 6;

    typedef logic signed [DATA_BW-1:0] sample_t;
    typedef logic signed [ERR_BW-1:0]  err_t;

    // PAM2 decision levels (+/-1.0 in S(9,7))
    localparam sample_t LVL_P1 = 9'sd128;
    localparam sample_t LVL_M1 = -9'sd128;

    // Clamp a signed value to the range of a w-bit two's complement word.
    // Result stays 32 bits wide; callers cast down to w bits.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/ffe_slicer_if.sv
// Sample/coefficient/decision bundle between the front-end, the FFE and the LMS stage.
interface ffe_slicer_if #(
    parameter int DATA_BW = ffe_slicer_pkg::DATA_BW,
    parameter int COEF_BW = ffe_slicer_pkg::COEF_BW,
    parameter int N_COEF  = ffe_slicer_pkg::N_COEF,
    parameter int ERR_BW  = ffe_slicer_pkg::ERR_BW
);
    logic                        i_en;
    logic signed [DATA_BW-1:0]   i_data;
    logic [COEF_BW*N_COEF-1:0]   i_coefs;
    logic signed [DATA_BW-1:0]   o_y;
    logic signed [DATA_BW-1:0]   o_dec;
    logic signed [ERR_BW-1:0]    o_err;
    logic                        o_valid;
    logic                        o_err_valid;

    // Sample source / coefficient provider side
    modport master (
        output i_en, i_data, i_coefs,
        input  o_y, o_dec, o_err, o_valid, o_err_valid
    );

    // Equalizer side
    modport slave (
        input  i_en, i_data, i_coefs,
        output o_y, o_dec, o_err, o_valid, o_err_valid
    );
endinterface

// File: rtl/ffe_sat_round.sv
// Arithmetic right shift with optional round-half-up, then saturate to OUT_W bits.
module ffe_sat_round
    import ffe_slicer_pkg::*;
#(
    parameter int IN_W  = 21,
    parameter int OUT_W = 9,
    parameter int SHIFT = 7,
    parameter bit ROUND = 1'b1
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);
    // Half an output LSB; zero selects plain truncation (floor)
    localparam logic signed [IN_W:0] HALF = ROUND ? ((IN_W + 1)'(1) <<< (SHIFT - 1)) : '0;

    logic signed [IN_W:0] sum_w;
    logic signed [IN_W:0] shr_w;
    logic signed [31:0]   ext_w;

    // One guard bit keeps the rounding add from wrapping at the positive limit
    assign sum_w = $signed({in_i[IN_W-1], in_i}) + HALF;
    assign shr_w = sum_w >>> SHIFT;
    assign ext_w = {{(31 - IN_W){shr_w[IN_W]}}, shr_w};
    assign out_o = OUT_W'(sat_s(ext_w, OUT_W));

endmodule

// File: rtl/ffe_slicer.sv
// Transposed-form FFE with PAM2 slicer and LMS error output.
// Stage 1: tap chain + equalized sample. Stage 2: decision and error.
module ffe_slicer #(
    parameter int DATA_BW  = ffe_slicer_pkg::DATA_BW,
    parameter int COEF_BW  = ffe_slicer_pkg::COEF_BW,
    parameter int N_COEF   = ffe_slicer_pkg::N_COEF,
    parameter int ERR_BW   = ffe_slicer_pkg::ERR_BW,
    parameter int N_WARMUP = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ffe_slicer_if.slave  bus
);
    import ffe_slicer_pkg::*;

    localparam int PROD_W = DATA_BW + COEF_BW;
    // Product width plus growth for N_COEF terms, never narrower than the shared accumulator width
    localparam int ACC_W  = (PROD_W + $clog2(N_COEF) > ACC_BW) ? PROD_W + $clog2(N_COEF) : ACC_BW;
    localparam int CNT_W  = $clog2(N_WARMUP + 1);

    logic signed [ACC_W-1:0]   p_w [N_COEF];
    logic signed [ACC_W-1:0]   s_d [1:N_COEF-1];
    logic signed [ACC_W-1:0]   s_q [1:N_COEF-1];
    logic signed [ACC_W-1:0]   acc_w;
    logic signed [ACC_W-1:0]   y_full_q;
    logic                      valid_q;
    logic                      warm_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;

    logic signed [DATA_BW-1:0] y_w;
    logic signed [DATA_BW-1:0] dec_d;
    logic signed [DATA_BW-1:0] dec_q;
    logic signed [DATA_BW:0]   e_w;
    logic signed [ERR_BW-1:0]  err_w;
    logic signed [ERR_BW-1:0]  err_d;
    logic signed [ERR_BW-1:0]  err_q;
    logic                      err_valid_q;

    // Full-precision products, sign-extended into accumulator width
    for (genvar k = 0; k < N_COEF; k++) begin : g_tap
        logic signed [PROD_W-1:0] prod;
        assign prod   = bus.i_data * $signed(bus.i_coefs[COEF_BW*k +: COEF_BW]);
        assign p_w[k] = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Transposed chain: each register carries the partial sum for a future output
    assign s_d[N_COEF-1] = p_w[N_COEF-1];
    for (genvar k = 1; k < N_COEF - 1; k++) begin : g_chain
        assign s_d[k] = p_w[k] + s_q[k+1];
    end
    assign acc_w = p_w[0] + s_q[1];

    // Warm-up counter saturates at N_WARMUP
    assign cnt_d = (cnt_q == CNT_W'(N_WARMUP)) ? cnt_q : cnt_q + CNT_W'(1);

    // Stage 1: advance the chain and capture the tap sum on each accepted sample
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 1; k < N_COEF; k++) s_q[k] <= '0;
            y_full_q <= '0;
            valid_q  <= 1'b0;
            warm_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q <= bus.i_en;
            if (bus.i_en) begin
                for (int k = 1; k < N_COEF; k++) s_q[k] <= s_d[k];
                y_full_q <= acc_w;
                // Tags this sample: warm once N_WARMUP samples preceded it
                warm_q   <= (cnt_q == CNT_W'(N_WARMUP));
                cnt_q    <= cnt_d;
            end
        end
    end

    // S(21,14) -> S(9,7), round half up, saturate
    ffe_sat_round #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_BW),
        .SHIFT (FRAC_COEF),
        .ROUND (1'b1)
    ) u_round_y (
        .in_i  (y_full_q),
        .out_o (y_w)
    );

    // Slicer: zero counts as +1
    assign dec_d = y_w[DATA_BW-1] ? LVL_M1 : LVL_P1;
    // d - y in S(10,7); range is +/-128 so one guard bit suffices
    assign e_w   = $signed({dec_d[DATA_BW-1], dec_d}) - $signed({y_w[DATA_BW-1], y_w});

    // S(10,7) -> S(8,6) by truncating one bit, then saturate
    ffe_sat_round #(
        .IN_W  (DATA_BW + 1),
        .OUT_W (ERR_BW),
        .SHIFT (FRAC_DATA - FRAC_ERR),
        .ROUND (1'b0)
    ) u_round_err (
        .in_i  (e_w),
        .out_o (err_w)
    );

    // Adaptation sees zero correction until the taps have been filled
    assign err_d = warm_q ? err_w : '0;

    // Stage 2: register decision and error one clock after each valid o_y
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dec_q       <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
        end else if (valid_q) begin
            dec_q       <= dec_d;
            err_q       <= err_d;
            err_valid_q <= warm_q;
        end
    end

    assign bus.o_y         = y_w;
    assign bus.o_valid     = valid_q;
    assign bus.o_dec       = dec_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_valid = err_valid_q;

endmodule

// File: tb/tb_ffe_slicer.sv
// Directed bench for ffe_slicer: identity, warm-up, saturation, gating, reset, rounding.
module tb_ffe_slicer;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ffe_slicer_if bus ();

    ffe_slicer #(.N_WARMUP(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected error word for a stage-1 value y: floor((dec - y) / 2), zero while not warm
    function automatic int exp_err(input int y, input bit v);
        int e;
        if (!v) return 0;
        e = ((y >= 0) ? 128 : -128) - y;
        return (e >= 0) ? e / 2 : -((1 - e) / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic en, input int d);
        bus.i_en   = en;
        bus.i_data = 9'(d);
        tick();
    endtask

    // Reset with i_en high and junk data: reset must win
    task automatic do_reset();
        rst        = 1'b1;
        bus.i_en   = 1'b1;
        bus.i_data = 9'(77);
        tick();
        rst        = 1'b0;
        bus.i_en   = 1'b0;
    endtask

    task automatic set_taps(input int idx, input int v, input int other);
        logic [62:0] c;
        for (int k = 0; k < 7; k++) c[9*k +: 9] = 9'((k == idx) ? v : other);
        bus.i_coefs = c;
    endtask

    task automatic test_reset();
        set_taps(0, 128, 0);
        do_reset();
        do_reset();
        checks++;
        if (int'(bus.o_y) !== 0 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_y got y=%0d valid=%b exp y=0 valid=0", int'(bus.o_y), bus.o_valid);
        end
        checks++;
        if (int'(bus.o_dec) !== 0 || int'(bus.o_err) !== 0 || bus.o_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_slicer got dec=%0d err=%0d ev=%b exp 0 0 0",
                     int'(bus.o_dec), int'(bus.o_err), bus.o_err_valid);
        end
    endtask

    task automatic test_identity();
        int ey [15];
        set_taps(3, 128, 0);
        do_reset();
        for (int j = 0; j < 15; j++) ey[j] = (j == 12) ? 100 : 0;
        for (int j = 0; j < 15; j++) begin
            push(1'b1, (j == 9) ? 100 : 0);
            checks++;
            if (int'(bus.o_y) !== ey[j] || bus.o_valid !== 1'b1) begin
                failures++;
                $display("FAIL identity_y[%0d] got y=%0d valid=%b exp y=%0d valid=1",
                         j, int'(bus.o_y), bus.o_valid, ey[j]);
            end
            if (j > 0) begin
                checks++;
                if (int'(bus.o_dec) !== 128 || int'(bus.o_err) !== exp_err(ey[j-1], j - 1 >= 8)
                    || bus.o_err_valid !== (j - 1 >= 8)) begin
                    failures++;
                    $display("FAIL identity_slicer[%0d] got dec=%0d err=%0d ev=%b exp dec=128 err=%0d ev=%b",
                             j - 1, int'(bus.o_dec), int'(bus.o_err), bus.o_err_valid,
                             exp_err(ey[j-1], j - 1 >= 8), (j - 1 >= 8));
                end
            end
        end
        push(1'b0, 0);
        checks++;
        if (bus.o_valid !== 1'b0 || int'(bus.o_dec) !== 128 || int'(bus.o_err) !== 64) begin
            failures++;
            $display("FAIL identity_tail got valid=%b dec=%0d err=%0d exp valid=0 dec=128 err=64",
                     bus.o_valid, int'(bus.o_dec), int'(bus.o_err));
        end
    endtask

    task automatic test_warmup();
        int d [12];
        set_taps(0, 128, 0);
        do_reset();
        for (int j = 0; j < 12; j++) begin
            d[j] = int'($urandom_range(400)) - 200;
            if (d[j] == 128 || d[j] == -128) d[j] = 0;
        end
        for (int j = 0; j < 12; j++) begin
            push(1'b1, d[j]);
            checks++;
            if (int'(bus.o_y) !== d[j]) begin
                failures++;
                $display("FAIL warmup_y[%0d] got %0d exp %0d", j, int'(bus.o_y), d[j]);
            end
            if (j > 0) begin
                checks++;
                if (int'(bus.o_err) !== exp_err(d[j-1], j - 1 >= 8) || bus.o_err_valid !== (j - 1 >= 8)) begin
                    failures++;
                    $display("FAIL warmup_err[%0d] got err=%0d ev=%b exp err=%0d ev=%b", j - 1,
                             int'(bus.o_err), bus.o_err_valid, exp_err(d[j-1], j - 1 >= 8), (j - 1 >= 8));
                end
            end
        end
    endtask

    task automatic test_saturation();
        int v;
        for (int pol = 0; pol < 2; pol++) begin
            v = (pol == 0) ? 255 : -256;
            set_taps(0, v, v);
            do_reset();
            for (int j = 0; j < 10; j++) begin
                push(1'b1, v);
                checks++;
                if (int'(bus.o_y) !== 255) begin
                    failures++;
                    $display("FAIL sat_y[pol=%0d,%0d] got %0d exp 255", pol, j, int'(bus.o_y));
                end
                if (j > 0) begin
                    checks++;
                    if (int'(bus.o_dec) !== 128 || int'(bus.o_err) !== ((j - 1 >= 8) ? -64 : 0)) begin
                        failures++;
                        $display("FAIL sat_slicer[pol=%0d,%0d] got dec=%0d err=%0d exp dec=128 err=%0d",
                                 pol, j - 1, int'(bus.o_dec), int'(bus.o_err), (j - 1 >= 8) ? -64 : 0);
                    end
                end
            end
        end
    endtask

    task automatic test_gated_enable();
        logic en [6];
        int   d  [6];
        int   ey [6];
        en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        d  = '{10, 77, 77, 20, 77, 30};
        ey = '{0, 0, 0, 10, 10, 20};
        set_taps(1, 128, 0);
        do_reset();
        for (int j = 0; j < 6; j++) begin
            push(en[j], d[j]);
            checks++;
            if (int'(bus.o_y) !== ey[j] || bus.o_valid !== en[j]) begin
                failures++;
                $display("FAIL gated[%0d] got y=%0d valid=%b exp y=%0d valid=%b",
                         j, int'(bus.o_y), bus.o_valid, ey[j], en[j]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_taps(2, 128, 0);
        do_reset();
        for (int j = 0; j < 10; j++) push(1'b1, 50);
        rst        = 1'b1;
        bus.i_en   = 1'b1;
        bus.i_data = 9'(50);
        tick();
        rst        = 1'b0;
        checks++;
        if (int'(bus.o_y) !== 0 || int'(bus.o_dec) !== 0 || int'(bus.o_err) !== 0
            || bus.o_valid !== 1'b0 || bus.o_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset got y=%0d dec=%0d err=%0d v=%b ev=%b exp all 0", int'(bus.o_y),
                     int'(bus.o_dec), int'(bus.o_err), bus.o_valid, bus.o_err_valid);
        end
        for (int j = 0; j < 10; j++) begin
            push(1'b1, 0);
            checks++;
            if (int'(bus.o_y) !== 0) begin
                failures++;
                $display("FAIL midreset_flush[%0d] got %0d exp 0", j, int'(bus.o_y));
            end
            if (j > 0) begin
                checks++;
                if (bus.o_err_valid !== (j - 1 >= 8) || int'(bus.o_err) !== exp_err(0, j - 1 >= 8)) begin
                    failures++;
                    $display("FAIL midreset_warm[%0d] got ev=%b err=%0d exp ev=%b err=%0d", j - 1,
                             bus.o_err_valid, int'(bus.o_err), (j - 1 >= 8), exp_err(0, j - 1 >= 8));
                end
            end
        end
    endtask

    task automatic test_zero_round();
        int d  [10];
        int ey [10];
        d  = '{64, 63, -64, -65, 5, 5, 5, 5, 0, -1};
        ey = '{1, 0, 0, -1, 5, 5, 5, 5, 0, -1};
        set_taps(0, 1, 0);
        do_reset();
        for (int j = 0; j < 10; j++) begin
            if (j == 4) set_taps(0, 128, 0);
            push(1'b1, d[j]);
            checks++;
            if (int'(bus.o_y) !== ey[j]) begin
                failures++;
                $display("FAIL round_y[%0d] got %0d exp %0d", j, int'(bus.o_y), ey[j]);
            end
            if (j > 0) begin
                checks++;
                if (int'(bus.o_dec) !== ((ey[j-1] >= 0) ? 128 : -128)
                    || int'(bus.o_err) !== exp_err(ey[j-1], j - 1 >= 8)) begin
                    failures++;
                    $display("FAIL round_slicer[%0d] got dec=%0d err=%0d exp dec=%0d err=%0d", j - 1,
                             int'(bus.o_dec), int'(bus.o_err), (ey[j-1] >= 0) ? 128 : -128,
                             exp_err(ey[j-1], j - 1 >= 8));
                end
            end
        end
        push(1'b0, 0);
        checks++;
        if (int'(bus.o_dec) !== -128 || int'(bus.o_err) !== -64 || bus.o_err_valid !== 1'b1) begin
            failures++;
            $display("FAIL round_tail got dec=%0d err=%0d ev=%b exp dec=-128 err=-64 ev=1",
                     int'(bus.o_dec), int'(bus.o_err), bus.o_err_valid);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_en    = 1'b0;
        bus.i_data  = '0;
        bus.i_coefs = '0;
        tick();
        test_reset();
        test_identity();
        test_warmup();
        test_saturation();
        test_gated_enable();
        test_reset_midstream();
        test_zero_round();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
